// File: rtl/pool_window_reader_pkg.sv
// Shared definitions for the 2x2 pooling window reader: FSM state encoding,
// most-negative pad value and default feature-map geometry.
// Optional feature macro: POOL_PAD_ODD_EN (pooled dims rounded up, edge lanes padded).
package pool_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD0,
      ST_RD1,
      ST_RD2,
      ST_RD3,
      ST_CAP,
      ST_VALID,
      ST_DONE
   } pool_state_e;

   localparam int POOL_DATA_W_DEF = 8;
   // Most-negative value for the default element width; never wins a max compare.
   localparam logic [POOL_DATA_W_DEF-1:0] POOL_NEG_PAD = {1'b1, {(POOL_DATA_W_DEF-1){1'b0}}};

   localparam int POOL_FMAP_W_DEF = 26;
   localparam int POOL_FMAP_H_DEF = 26;

   // Pooled dimension for a map dimension of n elements.
   function automatic int pool_dim(input int n);
`ifdef POOL_PAD_ODD_EN
      return (n + 1) / 2;
`else
      return n / 2;
`endif
   endfunction

endpackage

// File: rtl/pool_window_reader_addr_gen.sv
// Window row/col counters and conv-memory address generation for the pooling reader.
// Ports: clear_i/advance_i step the window counters; lane_i selects which of the four
// window elements rd_addr_o points at; win_index_o/last_o/pad_*_o describe the current window.
// Optional feature macro: POOL_PAD_ODD_EN (pad flags for lanes past the right/bottom edge).
module pool_addr_gen
   import pool_pkg::*;
#(
   parameter int addressWidthConv = 10,
   parameter int FMAP_W           = POOL_FMAP_W_DEF,
   parameter int FMAP_H           = POOL_FMAP_H_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clear_i,
   input  logic                        advance_i,
   input  logic [1:0]                  lane_i,
   output logic [addressWidthConv-1:0] rd_addr_o,
   output logic [addressWidthConv-1:0] win_index_o,
   output logic                        last_o,
   output logic                        pad_right_o,
   output logic                        pad_bottom_o
);

   localparam int AW = addressWidthConv;
   localparam int PW = pool_dim(FMAP_W);
   localparam int PH = pool_dim(FMAP_H);
   localparam logic [AW-1:0] MAP_W  = AW'(FMAP_W);
   localparam logic [AW-1:0] POOL_W = AW'(PW);
   localparam logic [AW-1:0] POOL_H = AW'(PH);
   localparam logic [AW-1:0] ONE    = AW'(1);

   logic [AW-1:0] row_q, row_d;
   logic [AW-1:0] col_q, col_d;
   logic [AW-1:0] base;

   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (clear_i) begin
         row_d = '0;
         col_d = '0;
      end else if (advance_i) begin
         if (col_q == POOL_W - ONE) begin
            col_d = '0;
            row_d = row_q + ONE;
         end else begin
            col_d = col_q + ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

   // Top-left element of the window: stride 2 in both directions.
   assign base = ((row_q << 1) * MAP_W) + (col_q << 1);

   always_comb begin
      rd_addr_o = base;
      case (lane_i)
         2'd1:    rd_addr_o = base + ONE;
         2'd2:    rd_addr_o = base + MAP_W;
         2'd3:    rd_addr_o = base + MAP_W + ONE;
         default: rd_addr_o = base;
      endcase
   end

   assign win_index_o = (row_q * POOL_W) + col_q;
   assign last_o      = (row_q == POOL_H - ONE) && (col_q == POOL_W - ONE);

`ifdef POOL_PAD_ODD_EN
   // Only the final column/row of an odd map can run past the edge.
   assign pad_right_o  = ((col_q << 1) + ONE) >= MAP_W;
   assign pad_bottom_o = ((row_q << 1) + ONE) >= AW'(FMAP_H);
`else
   assign pad_right_o  = 1'b0;
   assign pad_bottom_o = 1'b0;
`endif

endmodule

// File: rtl/pool_window_reader.sv
// Reads 2x2 stride-2 windows from the conv feature-map memory and presents them to the pooler.
// Latency: 6 cycles per window minimum (4 reads, 1 capture, 1 valid); backpressure: win_valid
// holds with data/index stable until win_ready, memory is idle while stalled.
// Ports: start/busy/done control, mem_rd_en/mem_addr/mem_rdata read side (1-cycle read latency),
// win_valid/win_ready handshake with win0..win3 (TL,TR,BL,BR) and pooled win_index.
// Optional feature macro: POOL_PAD_ODD_EN (odd maps rounded up, out-of-map lanes load most-negative).
module pool_window_reader
   import pool_pkg::*;
#(
   parameter int addressWidthConv = 10,
   parameter int dataWidthMax     = 8,
   parameter int FMAP_W           = POOL_FMAP_W_DEF,
   parameter int FMAP_H           = POOL_FMAP_H_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   output logic                        busy,
   output logic                        done,
   output logic                        mem_rd_en,
   output logic [addressWidthConv-1:0] mem_addr,
   input  logic [dataWidthMax-1:0]     mem_rdata,
   output logic                        win_valid,
   input  logic                        win_ready,
   output logic [dataWidthMax-1:0]     win0,
   output logic [dataWidthMax-1:0]     win1,
   output logic [dataWidthMax-1:0]     win2,
   output logic [dataWidthMax-1:0]     win3,
   output logic [addressWidthConv-1:0] win_index
);

   localparam logic [dataWidthMax-1:0] NEG_PAD = {1'b1, {(dataWidthMax-1){1'b0}}};

   if (FMAP_W * FMAP_H > (1 << addressWidthConv)) begin : g_map_too_big
      $error("pool_window_reader: feature map does not fit in conv address space");
   end

   pool_state_e state_q, state_d;

   logic [1:0]                  lane;
   logic                        rd_en;
   logic                        clear;
   logic                        advance;
   logic                        last;
   logic                        pad_right;
   logic                        pad_bottom;
   logic [addressWidthConv-1:0] rd_addr;
   logic [dataWidthMax-1:0]     win0_q, win1_q, win2_q, win3_q;

   always_comb begin
      state_d = state_q;
      lane    = 2'd0;
      rd_en   = 1'b0;
      unique case (state_q)
         ST_IDLE:  if (start) state_d = ST_RD0;
         ST_RD0: begin
            rd_en   = 1'b1;
            state_d = ST_RD1;
         end
         // Padded lanes keep their slot so window timing never depends on position.
         ST_RD1: begin
            lane    = 2'd1;
            rd_en   = !pad_right;
            state_d = ST_RD2;
         end
         ST_RD2: begin
            lane    = 2'd2;
            rd_en   = !pad_bottom;
            state_d = ST_RD3;
         end
         ST_RD3: begin
            lane    = 2'd3;
            rd_en   = !(pad_right || pad_bottom);
            state_d = ST_CAP;
         end
         ST_CAP:   state_d = ST_VALID;
         ST_VALID: if (win_ready) state_d = last ? ST_DONE : ST_RD0;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Counters restart on every accepted start so a pass always begins at window 0.
   assign clear   = (state_q == ST_IDLE) && start;
   assign advance = (state_q == ST_VALID) && win_ready && !last;

   pool_addr_gen #(
      .addressWidthConv (addressWidthConv),
      .FMAP_W           (FMAP_W),
      .FMAP_H           (FMAP_H)
   ) u_addr_gen (
      .clk          (clk),
      .rst          (rst),
      .clear_i      (clear),
      .advance_i    (advance),
      .lane_i       (lane),
      .rd_addr_o    (rd_addr),
      .win_index_o  (win_index),
      .last_o       (last),
      .pad_right_o  (pad_right),
      .pad_bottom_o (pad_bottom)
   );

   // Read data arrives one cycle after the request, so each lane lands one state later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win0_q <= '0;
         win1_q <= '0;
         win2_q <= '0;
         win3_q <= '0;
      end else begin
         case (state_q)
            ST_RD1:  win0_q <= mem_rdata;
            ST_RD2:  win1_q <= pad_right ? NEG_PAD : mem_rdata;
            ST_RD3:  win2_q <= pad_bottom ? NEG_PAD : mem_rdata;
            ST_CAP:  win3_q <= (pad_right || pad_bottom) ? NEG_PAD : mem_rdata;
            default: ;
         endcase
      end
   end

   assign mem_rd_en = rd_en;
   assign mem_addr  = rd_en ? rd_addr : '0;
   assign win_valid = (state_q == ST_VALID);
   assign done      = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign win0      = win0_q;
   assign win1      = win1_q;
   assign win2      = win2_q;
   assign win3      = win3_q;

endmodule

// File: tb/tb_pool_window_reader.sv
// Bench for pool_window_reader: three instances (4x4, 5x5, 26x26 maps) each with its own
// registered memory model; windows are checked against a reference built from the map
// contents, plus stall, signed-data, mid-pass reset and odd-map sequences.
module tb_pool_window_reader;

   logic       clk;
   logic       rst;
   logic       start     [3];
   logic       win_ready [3];
   logic       busy      [3];
   logic       done      [3];
   logic       rd_en     [3];
   logic [9:0] addr      [3];
   logic [7:0] rdata     [3];
   logic       win_valid [3];
   logic [7:0] w0 [3];
   logic [7:0] w1 [3];
   logic [7:0] w2 [3];
   logic [7:0] w3 [3];
   logic [9:0] widx [3];

   logic [7:0] mem [3][1024];
   int MW [3] = '{4, 5, 26};
   int MH [3] = '{4, 5, 26};

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] dat;
      logic [9:0]  idx;
   } obs_t;
   obs_t obs_q[$];
   int   last_base;

   typedef struct {
      logic [7:0]  m0, m1, m2, m3;
      logic [31:0] exp_dat;
   } vec_t;

   pool_window_reader #(.addressWidthConv(10), .dataWidthMax(8), .FMAP_W(4), .FMAP_H(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
      .mem_rd_en(rd_en[0]), .mem_addr(addr[0]), .mem_rdata(rdata[0]),
      .win_valid(win_valid[0]), .win_ready(win_ready[0]),
      .win0(w0[0]), .win1(w1[0]), .win2(w2[0]), .win3(w3[0]), .win_index(widx[0]));

   pool_window_reader #(.addressWidthConv(10), .dataWidthMax(8), .FMAP_W(5), .FMAP_H(5)) u_dut5 (
      .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
      .mem_rd_en(rd_en[1]), .mem_addr(addr[1]), .mem_rdata(rdata[1]),
      .win_valid(win_valid[1]), .win_ready(win_ready[1]),
      .win0(w0[1]), .win1(w1[1]), .win2(w2[1]), .win3(w3[1]), .win_index(widx[1]));

   pool_window_reader #(.addressWidthConv(10), .dataWidthMax(8), .FMAP_W(26), .FMAP_H(26)) u_dut26 (
      .clk(clk), .rst(rst), .start(start[2]), .busy(busy[2]), .done(done[2]),
      .mem_rd_en(rd_en[2]), .mem_addr(addr[2]), .mem_rdata(rdata[2]),
      .win_valid(win_valid[2]), .win_ready(win_ready[2]),
      .win0(w0[2]), .win1(w1[2]), .win2(w2[2]), .win3(w3[2]), .win_index(widx[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered single-port memories: data valid one cycle after the read enable.
   initial for (int k = 0; k < 3; k++) rdata[k] = 8'h00;
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++)
         if (rd_en[k]) rdata[k] <= mem[k][addr[k]];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int pdim(input int n);
`ifdef POOL_PAD_ODD_EN
      return (n + 1) / 2;
`else
      return n / 2;
`endif
   endfunction

   function automatic logic [7:0] elem(input int k, input int y, input int x);
      if (y < MH[k] && x < MW[k]) return mem[k][y * MW[k] + x];
      return 8'h80;
   endfunction

   function automatic logic [31:0] exp_win(input int k, input int w);
      int pw, r, c;
      pw = pdim(MW[k]);
      r  = w / pw;
      c  = w % pw;
      return {elem(k, 2*r, 2*c), elem(k, 2*r, 2*c+1), elem(k, 2*r+1, 2*c), elem(k, 2*r+1, 2*c+1)};
   endfunction

   function automatic logic [31:0] cur_win(input int k);
      return {w0[k], w1[k], w2[k], w3[k]};
   endfunction

   // One full pass on instance k; win_ready drops with probability stall_pct percent.
   task automatic run_pass(input int k, input int stall_pct);
      int n = 0, cyc = 0, ndone = 0, rptr = 0, last_acc = -1, first_addr = 0, nrd_win = 0;
      int nexp;
      logic [9:0] exp_addr[$];
      nexp = pdim(MW[k]) * pdim(MH[k]);
      for (int w = 0; w < nexp; w++) begin
         for (int l = 0; l < 4; l++) begin
            int y, x;
            y = 2 * (w / pdim(MW[k])) + l / 2;
            x = 2 * (w % pdim(MW[k])) + l % 2;
            if (y < MH[k] && x < MW[k]) exp_addr.push_back(10'(y * MW[k] + x));
         end
      end
      obs_q.delete();
      @(negedge clk); start[k] = 1'b1;
      @(negedge clk); start[k] = 1'b0;
      chk("busy_after_start", 32'(busy[k]), 32'd1);
      while (ndone == 0 && cyc < 20000) begin
         start[k]     = (cyc == 3);  // must be ignored while busy
         win_ready[k] = ($urandom_range(99) >= 32'(stall_pct));
         if (rd_en[k]) begin
            if (rptr < exp_addr.size()) chk("rd_addr", 32'(addr[k]), 32'(exp_addr[rptr]));
            else chk("extra_read", 32'(rptr), 32'(exp_addr.size()));
            if (nrd_win == 0) first_addr = int'(addr[k]);
            nrd_win++;
            rptr++;
         end
         if (win_valid[k]) begin
            chk("rd_en_in_valid", 32'(rd_en[k]), 32'd0);
            if (win_ready[k]) begin
               chk("win_data", cur_win(k), exp_win(k, n));
               chk("win_index", 32'(widx[k]), 32'(n));
               if (stall_pct == 0 && last_acc >= 0) chk("win_period", 32'(cyc - last_acc), 32'd6);
               last_acc  = cyc;
               last_base = first_addr;
               obs_q.push_back('{cur_win(k), widx[k]});
               nrd_win = 0;
               n++;
            end
         end
         if (done[k]) begin
            ndone++;
            chk("win_count_at_done", 32'(n), 32'(nexp));
            chk("busy_at_done", 32'(busy[k]), 32'd0);
         end
         @(negedge clk);
         cyc++;
      end
      start[k]     = 1'b0;
      win_ready[k] = 1'b1;
      if (ndone == 0) chk("pass_timeout", 32'(cyc), 32'd0);
      chk("read_count", 32'(rptr), 32'(exp_addr.size()));
      repeat (6) begin
         chk("post_idle", {28'd0, busy[k], done[k], win_valid[k], rd_en[k]}, 32'd0);
         @(negedge clk);
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      obs_t tbl4[4];
      vec_t nv[3];
      int   tmo;

      tbl4[0] = '{32'h00010405, 10'd0};
      tbl4[1] = '{32'h02030607, 10'd1};
      tbl4[2] = '{32'h08090C0D, 10'd2};
      tbl4[3] = '{32'h0A0B0E0F, 10'd3};
      nv[0] = '{8'h80, 8'hFF, 8'h7F, 8'h00, 32'h80FF7F00};
      nv[1] = '{8'h01, 8'hFE, 8'h81, 8'h7E, 32'h01FE817E};
      nv[2] = '{8'hC3, 8'h3C, 8'hAA, 8'h55, 32'hC33CAA55};

      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         start[k] = 1'b0;
         win_ready[k] = 1'b1;
         for (int a = 0; a < 1024; a++) mem[k][a] = 8'(a);
      end
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("reset_ctrl", {28'd0, busy[k], done[k], win_valid[k], rd_en[k]}, 32'd0);
         chk("reset_data", cur_win(k), 32'd0);
         chk("reset_addr_idx", {12'd0, addr[k], widx[k]}, 32'd0);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // 4x4 identity map, ready always high
      run_pass(0, 0);
      chk("tbl4_count", 32'(obs_q.size()), 32'd4);
      if (obs_q.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("tbl4_dat", obs_q[i].dat, tbl4[i].dat);
            chk("tbl4_idx", 32'(obs_q[i].idx), 32'(tbl4[i].idx));
         end
      end

      // Consumer stalls 10 cycles on the first window
      @(negedge clk); start[0] = 1'b1; win_ready[0] = 1'b0;
      @(negedge clk); start[0] = 1'b0;
      tmo = 0;
      while (!win_valid[0] && tmo < 20) begin @(negedge clk); tmo++; end
      chk("stall_reach_valid", 32'(win_valid[0]), 32'd1);
      repeat (10) begin
         chk("stall_hold", {win_valid[0], rd_en[0], 30'd0}, {1'b1, 1'b0, 30'd0});
         chk("stall_data", cur_win(0), 32'h00010405);
         @(negedge clk);
      end
      win_ready[0] = 1'b1;
      @(negedge clk);
      chk("resume_rd0", {21'd0, rd_en[0], addr[0]}, {21'd0, 1'b1, 10'd2});
      tmo = 0;
      while (!done[0] && tmo < 40) begin @(negedge clk); tmo++; end
      chk("stall_pass_done", 32'(done[0]), 32'd1);
      repeat (2) @(negedge clk);

      // Signed bytes must pass through untouched
      for (int i = 0; i < 3; i++) begin
         mem[0][0] = nv[i].m0; mem[0][1] = nv[i].m1;
         mem[0][4] = nv[i].m2; mem[0][5] = nv[i].m3;
         run_pass(0, 0);
         if (obs_q.size() > 0) chk("signed_win0", obs_q[0].dat, nv[i].exp_dat);
         else chk("signed_win0_missing", 32'(obs_q.size()), 32'd4);
      end

      // Asynchronous reset during RD2 of window 0
      for (int a = 0; a < 16; a++) mem[0][a] = 8'(a);
      @(negedge clk); start[0] = 1'b1;
      @(negedge clk); start[0] = 1'b0;
      tmo = 0;
      while (!(rd_en[0] && addr[0] == 10'd4) && tmo < 20) begin @(negedge clk); tmo++; end
      chk("reach_rd2", {21'd0, rd_en[0], addr[0]}, {21'd0, 1'b1, 10'd4});
      rst = 1'b1;
      #1;
      chk("midrst_ctrl", {28'd0, busy[0], done[0], win_valid[0], rd_en[0]}, 32'd0);
      chk("midrst_data", cur_win(0), 32'd0);
      chk("midrst_addr_idx", {12'd0, addr[0], widx[0]}, 32'd0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      chk("midrst_idle", 32'(busy[0]), 32'd0);
      run_pass(0, 0);
      chk("restart_count", 32'(obs_q.size()), 32'd4);

      // 5x5 odd map
      for (int a = 0; a < 25; a++) mem[1][a] = 8'(a);
      run_pass(1, 0);
`ifdef POOL_PAD_ODD_EN
      chk("odd_count", 32'(obs_q.size()), 32'd9);
      if (obs_q.size() == 9) begin
         chk("odd_win2", obs_q[2].dat, 32'h04800980);
         chk("odd_win8", obs_q[8].dat, 32'h18808080);
         chk("odd_idx8", 32'(obs_q[8].idx), 32'd8);
      end
`else
      chk("odd_count", 32'(obs_q.size()), 32'd4);
      chk("odd_last_base", 32'(last_base), 32'd12);
`endif

      // Default 26x26 map with random data and random backpressure
      for (int a = 0; a < 676; a++) mem[2][a] = 8'($urandom);
      run_pass(2, 30);
      chk("full_count", 32'(obs_q.size()), 32'd169);
      if (obs_q.size() > 0) chk("full_last_idx", 32'(obs_q[obs_q.size()-1].idx), 32'd168);
      chk("full_last_base", 32'(last_base), 32'd648);

      // Random data and stalls on the small maps
      for (int it = 0; it < 3; it++) begin
         for (int a = 0; a < 25; a++) begin
            mem[0][a] = 8'($urandom);
            mem[1][a] = 8'($urandom);
         end
         run_pass(0, 25);
         run_pass(1, 40);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pool_window_reader.md
Name: pool_window_reader

Overview:
- Reads 2x2 windows, raster order with stride 2, from the single-port convolution feature-map memory.
- Presents the four window values to the max-pooling stage over a valid/ready handshake.
- Also outputs the pooled output index, so downstream logic can write the pooled result.
- Sits between the conv result BRAM (read side) and the pooling comparator.

Parameters:
- addressWidthConv, 10, width of conv memory address and of pooled index.
- dataWidthMax, 8, width of one signed feature-map element.
- FMAP_W, 26, feature-map width in elements.
- FMAP_H, 26, feature-map height in elements.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a full-map pass when idle.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the last window is accepted.
- mem_rd_en  out  1  conv memory read enable.
- mem_addr  out  addressWidthConv  conv memory read address.
- mem_rdata  in  dataWidthMax  read data; registered memory, valid exactly 1 cycle after mem_rd_en.
- win_valid  out  1  window values and index are valid.
- win_ready  in  1  consumer accepts the window.
- win0, win1, win2, win3  out  dataWidthMax each  window elements: top-left, top-right, bottom-left, bottom-right.
- win_index  out  addressWidthConv  pooled index, r*(FMAP_W/2)+c.

Behaviour:
- Reset (async): all outputs 0, state IDLE, row/col counters 0.
- States: IDLE, RD0, RD1, RD2, RD3, CAP, VALID, DONE.
- IDLE -> RD0 on start. Start is ignored in every other state.
- Window base address: base = 2r*FMAP_W + 2c.
- Read addresses, issued with mem_rd_en=1:
  - RD0: base
  - RD1: base+1
  - RD2: base+FMAP_W
  - RD3: base+FMAP_W+1
- Captures (one cycle after each read):
  - win0 in RD1
  - win1 in RD2
  - win2 in RD3
  - win3 in CAP
- mem_rd_en=0 in CAP, VALID, IDLE and DONE.
- VALID: win_valid=1. win0..3 and win_index are held stable until win_ready=1.
- Acceptance (win_valid & win_ready), same cycle:
  - if last window -> DONE; otherwise advance c (wrap to 0 with r+1) -> RD0.
  - Minimum 6 cycles per window with win_ready held high.
- DONE: done=1 for one cycle, busy drops with it, then IDLE. Data outputs keep their last values.
- Signed data passes through unmodified; no arithmetic on data.
- Pooled dims: FMAP_W/2 x FMAP_H/2, floor. Odd trailing row/col is dropped unless the optional feature is enabled.
- Elaboration error if FMAP_W*FMAP_H > 2**addressWidthConv.
- Reset mid-operation: immediate return to IDLE with counters cleared. The next start restarts at window 0.

Optional Feature:
- Macro: POOL_PAD_ODD_EN.
- Enabled:
  - Pooled dims are ceil(FMAP_W/2) x ceil(FMAP_H/2).
  - Lanes falling outside the map are not read; they load -2**(dataWidthMax-1) (e.g. -128).
  - The corresponding RDx state still elapses but with mem_rd_en=0, so timing is unchanged.
- Disabled: floor behaviour as above; no pad logic.

Decomposition:
- Shared package pool_pkg:
  - state encoding enum
  - POOL_NEG_PAD constant (most-negative value per dataWidthMax)
  - default FMAP_W/FMAP_H
- One sub-module pool_addr_gen:
  - row/col counters, base/offset address computation, win_index, last-window flag
  - pad-lane flags under POOL_PAD_ODD_EN
- The FSM and capture registers stay in the top module.

Test Plan:
- FMAP 4x4, mem[a]=a, win_ready=1, start -> windows (0,1,4,5),(2,3,6,7),(8,9,12,13),(10,11,14,15).
  - win_index 0..3, 6 cycles apart; done pulse once after 4th acceptance; busy low afterward.
- Same map, win_ready low 10 cycles at first VALID -> win_valid held, win0..3=(0,1,4,5) stable, mem_rd_en=0 throughout. Raising ready advances to RD0 next cycle.
- Negative data: mem = 8'h80, 8'hFF, 8'h7F, 8'h00 at window 0 -> win0..3 equal exactly those bytes (no sign mangling).
- rst asserted asynchronously during RD2 -> all outputs 0 immediately, state IDLE. Subsequent start re-reads window 0 from address 0; start pulsed while busy has no effect.
- FMAP 5x5:
  - with POOL_PAD_ODD_EN -> 9 windows; window index 2 = (4, -128, 9, -128); index 8 = (24, -128, -128, -128).
  - without the macro -> 4 windows; last base address 12.
- Default 26x26 -> 169 windows, last win_index 168, last base address 648, then one done pulse.
